// File: rtl/xm23_pkg.sv
// Shared XM23 sequencer definitions: FSM states, memory control bit
// positions, MAR source codes and the PSW SLP bit position.
package xm23_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_F_ADDR = 3'd1,
      S_F_MEM  = 3'd2,
      S_F_IR   = 3'd3,
      S_EXEC   = 3'd4,
      S_D_MEM  = 3'd5,
      S_WBACK  = 3'd6,
      S_BRK    = 3'd7
   } state_t;

   // Memory control word {W/B, R/W, EN}
   localparam int CTRL_EN   = 0;
   localparam int CTRL_WR   = 1;
   localparam int CTRL_BYTE = 2;

   // MAR source select
   localparam logic [1:0] MAR_HOLD = 2'd0;
   localparam logic [1:0] MAR_PC   = 2'd1;
   localparam logic [1:0] MAR_EA   = 2'd2;

   // SLP bit position in the PSW (the sequencer receives it already extracted)
   localparam int PSW_SLP_BIT = 3;

   // Build an enabled memory control word
   function automatic logic [2:0] ctrl_word(input logic byte_acc, input logic wr);
      logic [2:0] w;
      w            = '0;
      w[CTRL_EN]   = 1'b1;
      w[CTRL_WR]   = wr;
      w[CTRL_BYTE] = byte_acc;
      return w;
   endfunction

endpackage

// File: rtl/xm23_run_ctrl.sv
// Front-panel run control: step request latch, breakpoint bypass flag and
// breakpoint compare. Produces the IDLE launch / halt decisions.
module xm23_run_ctrl
   import xm23_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  state_t      i_state,
   input  logic        i_step,
   input  logic        i_run_mode,
   input  logic        i_slp,
   input  logic        i_bkpnt_en,
   input  logic [15:0] i_bkpnt,
   input  logic [15:0] i_pc,
   output logic        o_launch,
   output logic        o_brk_hit
);

   logic r_step_pend;
   logic r_bypass;
   logic w_idle_awake;

   // Decisions are only taken in IDLE; SLP blocks both fetch and breakpoint.
   // The compare uses the pre-fetch pc, so detection costs no extra cycle.
   always_comb begin
      w_idle_awake = (i_state == S_IDLE) && !i_slp;
      o_brk_hit    = w_idle_awake && i_bkpnt_en && (i_pc == i_bkpnt) && !r_bypass;
      o_launch     = w_idle_awake && !o_brk_hit && (i_run_mode || r_step_pend);
   end

   // Step latch (cleared as F_ADDR is entered) and one-shot breakpoint bypass
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_step_pend <= 1'b0;
         r_bypass    <= 1'b0;
      end else begin
         if (o_launch)
            r_step_pend <= 1'b0;
         else if (i_step && (i_state != S_BRK))
            r_step_pend <= 1'b1;

         if ((i_state == S_BRK) && i_step)
            r_bypass <= 1'b1;
         else if (i_state == S_F_ADDR)
            r_bypass <= 1'b0;
      end
   end

endmodule

// File: rtl/xm23_sequencer.sv
// XM23 fetch/execute sequencer. Two-process FSM; every output is a
// registered decode of the next state so it lines up with the state register.
module xm23_sequencer
   import xm23_pkg::*;
(
   input  logic        Clock,
   input  logic        Reset,
   input  logic        run_mode,
   input  logic        step,
   input  logic        bkpnt_en,
   input  logic [15:0] bkpnt,
   input  logic [15:0] pc,
   input  logic        slp,
   input  logic        mem_ack,
   input  logic        dec_mem,
   input  logic        dec_wr,
   input  logic        dec_byte,
   output logic [2:0]  ctrl_out,
   output logic [1:0]  mar_sel,
   output logic        ir_ld,
   output logic        pc_inc,
   output logic        exec_en,
   output logic        wb_en,
   output logic        running,
   output logic        halted,
   output logic [2:0]  state
);

   state_t     r_state, w_state_nxt;
   logic       r_dec_mem, r_dec_wr, r_dec_byte;
   logic       w_dec_mem, w_dec_wr, w_dec_byte;
   logic       w_launch, w_brk_hit;

   logic [2:0] r_ctrl, w_ctrl;
   logic [1:0] r_mar, w_mar;
   logic       r_ir_ld, w_ir_ld;
   logic       r_pc_inc, w_pc_inc;
   logic       r_exec_en, w_exec_en;
   logic       r_wb_en, w_wb_en;
   logic       r_running, w_running;
   logic       r_halted, w_halted;

   xm23_run_ctrl u_run_ctrl (
      .i_clk      (Clock),
      .i_rst      (Reset),
      .i_state    (r_state),
      .i_step     (step),
      .i_run_mode (run_mode),
      .i_slp      (slp),
      .i_bkpnt_en (bkpnt_en),
      .i_bkpnt    (bkpnt),
      .i_pc       (pc),
      .o_launch   (w_launch),
      .o_brk_hit  (w_brk_hit)
   );

   // Decoder fields are sampled as EXEC is entered so that EXEC's registered
   // mar_sel and the following D_MEM control word can both reflect them.
   always_comb begin
      w_dec_mem  = r_dec_mem;
      w_dec_wr   = r_dec_wr;
      w_dec_byte = r_dec_byte;
      if (r_state == S_F_IR) begin
         w_dec_mem  = dec_mem;
         w_dec_wr   = dec_wr;
         w_dec_byte = dec_byte;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_brk_hit)
               w_state_nxt = S_BRK;
            else if (w_launch)
               w_state_nxt = S_F_ADDR;
         end
         S_F_ADDR: w_state_nxt = S_F_MEM;
         S_F_MEM:  if (mem_ack) w_state_nxt = S_F_IR;
         S_F_IR:   w_state_nxt = S_EXEC;
         S_EXEC:   w_state_nxt = r_dec_mem ? S_D_MEM : S_WBACK;
         S_D_MEM:  if (mem_ack) w_state_nxt = r_dec_wr ? S_IDLE : S_WBACK;
         S_WBACK:  w_state_nxt = S_IDLE;
         S_BRK:    if (step || !bkpnt_en) w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // Output decode of the state being entered
   always_comb begin
      w_ctrl    = 3'b000;
      w_mar     = MAR_HOLD;
      w_ir_ld   = 1'b0;
      w_pc_inc  = 1'b0;
      w_exec_en = 1'b0;
      w_wb_en   = 1'b0;
      w_running = 1'b0;
      w_halted  = 1'b0;
      case (w_state_nxt)
         S_F_ADDR: begin
            w_mar     = MAR_PC;
            w_running = 1'b1;
         end
         S_F_MEM: begin
            w_ctrl    = ctrl_word(1'b0, 1'b0);
            w_running = 1'b1;
         end
         S_F_IR: begin
            w_ir_ld   = 1'b1;
            w_pc_inc  = 1'b1;
            w_running = 1'b1;
         end
         S_EXEC: begin
            w_exec_en = 1'b1;
            w_mar     = w_dec_mem ? MAR_EA : MAR_HOLD;
            w_running = 1'b1;
         end
         S_D_MEM: begin
            w_ctrl    = ctrl_word(w_dec_byte, w_dec_wr);
            w_running = 1'b1;
         end
         S_WBACK: begin
            w_wb_en   = 1'b1;
            w_running = 1'b1;
         end
         S_BRK:    w_halted = 1'b1;
         default:  w_running = 1'b0;
      endcase
   end

   // State, captured decoder fields and registered outputs; reset abandons
   // any access in flight
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state    <= S_IDLE;
         r_dec_mem  <= 1'b0;
         r_dec_wr   <= 1'b0;
         r_dec_byte <= 1'b0;
         r_ctrl     <= 3'b000;
         r_mar      <= MAR_HOLD;
         r_ir_ld    <= 1'b0;
         r_pc_inc   <= 1'b0;
         r_exec_en  <= 1'b0;
         r_wb_en    <= 1'b0;
         r_running  <= 1'b0;
         r_halted   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_dec_mem  <= w_dec_mem;
         r_dec_wr   <= w_dec_wr;
         r_dec_byte <= w_dec_byte;
         r_ctrl     <= w_ctrl;
         r_mar      <= w_mar;
         r_ir_ld    <= w_ir_ld;
         r_pc_inc   <= w_pc_inc;
         r_exec_en  <= w_exec_en;
         r_wb_en    <= w_wb_en;
         r_running  <= w_running;
         r_halted   <= w_halted;
      end
   end

   assign ctrl_out = r_ctrl;
   assign mar_sel  = r_mar;
   assign ir_ld    = r_ir_ld;
   assign pc_inc   = r_pc_inc;
   assign exec_en  = r_exec_en;
   assign wb_en    = r_wb_en;
   assign running  = r_running;
   assign halted   = r_halted;
   assign state    = r_state;

endmodule

// File: tb/tb_xm23_sequencer.sv
// Directed bench for xm23_sequencer: one task per scenario, expected values
// written out by hand from the state walk of each instruction class.
module tb_xm23_sequencer;

   logic        Clock, Reset, run_mode, step, bkpnt_en, slp, mem_ack;
   logic        dec_mem, dec_wr, dec_byte;
   logic [15:0] bkpnt, pc;
   logic [2:0]  ctrl_out, state;
   logic [1:0]  mar_sel;
   logic        ir_ld, pc_inc, exec_en, wb_en, running, halted;

   logic        pc_load;
   logic [15:0] pc_load_val;

   int checks   = 0;
   int failures = 0;

   xm23_sequencer dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .run_mode (run_mode),
      .step     (step),
      .bkpnt_en (bkpnt_en),
      .bkpnt    (bkpnt),
      .pc       (pc),
      .slp      (slp),
      .mem_ack  (mem_ack),
      .dec_mem  (dec_mem),
      .dec_wr   (dec_wr),
      .dec_byte (dec_byte),
      .ctrl_out (ctrl_out),
      .mar_sel  (mar_sel),
      .ir_ld    (ir_ld),
      .pc_inc   (pc_inc),
      .exec_en  (exec_en),
      .wb_en    (wb_en),
      .running  (running),
      .halted   (halted),
      .state    (state)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // R7 stand-in: loadable, advances by 2 on pc_inc
   always @(posedge Clock) begin
      if (pc_load)
         pc <= pc_load_val;
      else if (pc_inc)
         pc <= pc + 16'd2;
   end

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      tick();
      tick();
      Reset = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      tick();
      tick();
      checks++;
      if ({ctrl_out, mar_sel, ir_ld, pc_inc, exec_en, wb_en, running, halted, state} !== 14'h0) begin
         failures++;
         $display("FAIL reset_outputs: got %h expected 0000",
                  {ctrl_out, mar_sel, ir_ld, pc_inc, exec_en, wb_en, running, halted, state});
      end
      Reset = 1'b0;
      tick();
      checks++;
      if (state !== 3'd0) begin
         failures++;
         $display("FAIL reset_idle_hold: state=%0d expected 0", state);
      end
   endtask

   task automatic test_step_regop();
      logic [2:0] exp_st [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd0, 3'd0};
      do_reset();
      run_mode = 1'b0; mem_ack = 1'b1; dec_mem = 1'b0; dec_wr = 1'b0; dec_byte = 1'b0;
      step = 1'b1;
      tick();
      step = 1'b0;
      checks++;
      if (state !== 3'd0) begin
         failures++;
         $display("FAIL regop_step_latch: state=%0d expected 0", state);
      end
      for (int i = 0; i < 7; i++) begin
         tick();
         checks++;
         if (state !== exp_st[i]) begin
            failures++;
            $display("FAIL regop_state[%0d]: state=%0d expected %0d", i, state, exp_st[i]);
         end
         checks++;
         if ({ir_ld, pc_inc} !== ((exp_st[i] == 3'd3) ? 2'b11 : 2'b00)) begin
            failures++;
            $display("FAIL regop_irld[%0d]: ir_ld/pc_inc=%b in state %0d", i, {ir_ld, pc_inc}, exp_st[i]);
         end
         checks++;
         if ({exec_en, wb_en} !== {exp_st[i] == 3'd4, exp_st[i] == 3'd6}) begin
            failures++;
            $display("FAIL regop_exec_wb[%0d]: exec_en/wb_en=%b in state %0d", i, {exec_en, wb_en}, exp_st[i]);
         end
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (state !== 3'd0) begin
            failures++;
            $display("FAIL regop_no_refetch[%0d]: state=%0d expected 0", i, state);
         end
      end
   endtask

   task automatic test_load_wait();
      logic       ack  [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [2:0] st   [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd0};
      logic [2:0] ctl  [8] = '{3'b000, 3'b001, 3'b000, 3'b000, 3'b101, 3'b101, 3'b000, 3'b000};
      logic [1:0] mar  [8] = '{2'd1, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0};
      logic       wb   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      do_reset();
      run_mode = 1'b0; mem_ack = 1'b0; dec_mem = 1'b1; dec_wr = 1'b0; dec_byte = 1'b1;
      step = 1'b1;
      tick();
      step = 1'b0;
      for (int i = 0; i < 8; i++) begin
         mem_ack = ack[i];
         tick();
         checks++;
         if ({state, ctrl_out, mar_sel, wb_en} !== {st[i], ctl[i], mar[i], wb[i]}) begin
            failures++;
            $display("FAIL load_cycle[%0d]: state=%0d ctrl=%b mar=%0d wb=%b expected state=%0d ctrl=%b mar=%0d wb=%b",
                     i, state, ctrl_out, mar_sel, wb_en, st[i], ctl[i], mar[i], wb[i]);
         end
      end
      mem_ack = 1'b0;
   endtask

   task automatic test_store();
      logic       ack  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      logic [2:0] st   [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd0};
      logic [2:0] ctl  [7] = '{3'b000, 3'b001, 3'b000, 3'b000, 3'b011, 3'b000, 3'b000};
      logic [1:0] mar  [7] = '{2'd1, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0};
      do_reset();
      run_mode = 1'b0; mem_ack = 1'b0; dec_mem = 1'b1; dec_wr = 1'b1; dec_byte = 1'b0;
      step = 1'b1;
      tick();
      step = 1'b0;
      for (int i = 0; i < 7; i++) begin
         mem_ack = ack[i];
         tick();
         checks++;
         if ({state, ctrl_out, mar_sel, wb_en} !== {st[i], ctl[i], mar[i], 1'b0}) begin
            failures++;
            $display("FAIL store_cycle[%0d]: state=%0d ctrl=%b mar=%0d wb=%b expected state=%0d ctrl=%b mar=%0d wb=0",
                     i, state, ctrl_out, mar_sel, wb_en, st[i], ctl[i], mar[i]);
         end
      end
      mem_ack = 1'b0; dec_mem = 1'b0; dec_wr = 1'b0;
   endtask

   task automatic test_breakpoint();
      int          n_fetch = 0;
      logic [15:0] fpc [2] = '{16'h0, 16'h0};
      bit          done    = 0;
      run_mode = 1'b0; dec_mem = 1'b0; mem_ack = 1'b1;
      bkpnt = 16'h0104; bkpnt_en = 1'b1;
      pc_load = 1'b1; pc_load_val = 16'h0100;
      do_reset();
      pc_load = 1'b0;
      run_mode = 1'b1;
      for (int i = 0; i < 40 && !done; i++) begin
         tick();
         if (state == 3'd1) begin
            if (n_fetch < 2) fpc[n_fetch] = pc;
            n_fetch++;
         end
         if (state == 3'd7) done = 1;
      end
      checks++;
      if (!done) begin
         failures++;
         $display("FAIL brk_reach: timeout, state=%0d expected 7", state);
      end
      checks++;
      if ({n_fetch, fpc[0], fpc[1]} !== {32'd2, 16'h0100, 16'h0102}) begin
         failures++;
         $display("FAIL brk_fetches: count=%0d pcs=%h,%h expected 2 at 0100,0102", n_fetch, fpc[0], fpc[1]);
      end
      checks++;
      if ({halted, running, pc} !== {1'b1, 1'b0, 16'h0104}) begin
         failures++;
         $display("FAIL brk_flags: halted=%b running=%b pc=%h expected 1 0 0104", halted, running, pc);
      end
      tick(); tick(); tick();
      checks++;
      if ({state, halted} !== {3'd7, 1'b1}) begin
         failures++;
         $display("FAIL brk_hold: state=%0d halted=%b expected 7 1", state, halted);
      end
      step = 1'b1;
      tick();
      step = 1'b0;
      checks++;
      if ({state, halted} !== {3'd0, 1'b0}) begin
         failures++;
         $display("FAIL brk_step_exit: state=%0d halted=%b expected 0 0", state, halted);
      end
      tick();
      checks++;
      if ({state, pc} !== {3'd1, 16'h0104}) begin
         failures++;
         $display("FAIL brk_bypass_fetch: state=%0d pc=%h expected 1 0104", state, pc);
      end
      for (int i = 0; i < 20 && state != 3'd6; i++) tick();
      tick();
      tick();
      checks++;
      if ({state, pc} !== {3'd1, 16'h0106}) begin
         failures++;
         $display("FAIL brk_next_fetch: state=%0d pc=%h expected 1 0106", state, pc);
      end
      for (int i = 0; i < 20 && state != 3'd6; i++) tick();
      checks++;
      if (state !== 3'd6) begin
         failures++;
         $display("FAIL brk_wback_wait: timeout, state=%0d expected 6", state);
      end
      pc_load = 1'b1; pc_load_val = 16'h0104;
      tick();
      pc_load = 1'b0;
      tick();
      checks++;
      if ({state, halted} !== {3'd7, 1'b1}) begin
         failures++;
         $display("FAIL brk_rehit: state=%0d halted=%b expected 7 1", state, halted);
      end
      bkpnt_en = 1'b0; run_mode = 1'b0;
      tick();
      tick();
      checks++;
      if ({state, halted} !== {3'd0, 1'b0}) begin
         failures++;
         $display("FAIL brk_disarm_exit: state=%0d halted=%b expected 0 0", state, halted);
      end
   endtask

   task automatic test_slp();
      run_mode = 1'b0; bkpnt_en = 1'b0; mem_ack = 1'b1; dec_mem = 1'b0; slp = 1'b1;
      do_reset();
      run_mode = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if ({state, running} !== {3'd0, 1'b0}) begin
            failures++;
            $display("FAIL slp_idle[%0d]: state=%0d running=%b expected 0 0", i, state, running);
         end
      end
      slp = 1'b0;
      tick();
      checks++;
      if ({state, running} !== {3'd1, 1'b1}) begin
         failures++;
         $display("FAIL slp_wake: state=%0d running=%b expected 1 1", state, running);
      end
      run_mode = 1'b0;
      for (int i = 0; i < 20 && state != 3'd0; i++) tick();
      checks++;
      if (state !== 3'd0) begin
         failures++;
         $display("FAIL slp_finish: timeout, state=%0d expected 0", state);
      end
   endtask

   task automatic test_reset_midaccess();
      run_mode = 1'b0; bkpnt_en = 1'b0; slp = 1'b0; mem_ack = 1'b0; dec_mem = 1'b0; dec_wr = 1'b0;
      do_reset();
      step = 1'b1;
      tick();
      step = 1'b0;
      tick();
      tick();
      checks++;
      if ({state, ctrl_out} !== {3'd2, 3'b001}) begin
         failures++;
         $display("FAIL rst_fmem_setup: state=%0d ctrl=%b expected 2 001", state, ctrl_out);
      end
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      checks++;
      if ({ctrl_out, mar_sel, ir_ld, pc_inc, exec_en, wb_en, running, halted, state} !== 14'h0) begin
         failures++;
         $display("FAIL rst_fmem: outputs=%h expected 0000",
                  {ctrl_out, mar_sel, ir_ld, pc_inc, exec_en, wb_en, running, halted, state});
      end
      dec_mem = 1'b1; dec_wr = 1'b1;
      step = 1'b1;
      tick();
      step = 1'b0;
      tick();
      tick();
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      tick();
      tick();
      checks++;
      if ({state, ctrl_out} !== {3'd5, 3'b011}) begin
         failures++;
         $display("FAIL rst_dmem_setup: state=%0d ctrl=%b expected 5 011", state, ctrl_out);
      end
      step = 1'b1;
      tick();
      step = 1'b0;
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      checks++;
      if ({ctrl_out, mar_sel, ir_ld, pc_inc, exec_en, wb_en, running, halted, state} !== 14'h0) begin
         failures++;
         $display("FAIL rst_dmem: outputs=%h expected 0000",
                  {ctrl_out, mar_sel, ir_ld, pc_inc, exec_en, wb_en, running, halted, state});
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (state !== 3'd0) begin
            failures++;
            $display("FAIL rst_pend_cleared[%0d]: state=%0d expected 0", i, state);
         end
      end
      dec_mem = 1'b0; dec_wr = 1'b0;
   endtask

   initial begin
      Reset = 1'b1; run_mode = 1'b0; step = 1'b0; bkpnt_en = 1'b0; bkpnt = 16'h0;
      slp = 1'b0; mem_ack = 1'b0; dec_mem = 1'b0; dec_wr = 1'b0; dec_byte = 1'b0;
      pc_load = 1'b1; pc_load_val = 16'h0;
      test_reset();
      pc_load = 1'b0;
      test_step_regop();
      test_load_wait();
      test_store();
      test_breakpoint();
      test_slp();
      test_reset_midaccess();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
